// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter that shares the single write port of
// the register file among NUM_REQ writeback sources. The granted write is
// registered and presented to the register file (and to forwarding logic) one
// cycle after acceptance.
// Optional build macro: WB_ZERO_REG_EN -- accepted writes to address 0 never
// raise write_enable, so register 0 stays untouched.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wb_stall,
    output logic                        write_enable,
    output logic [ADDR_W-1:0]           write_addr,
    output logic [DATA_W-1:0]           write_data,
    output logic                        inflight_valid,
    output logic [ADDR_W-1:0]           inflight_addr,
    output logic [15:0]                 grant_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic              accept;
    logic              wr_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    int                idx;

    // Search req_valid from rr_ptr upward, wrapping; first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        accept    = 1'b0;
        idx       = 0;
        if (!wb_stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!accept && req_valid[idx[PTR_W-1:0]]) begin
                    accept                    = 1'b1;
                    req_ready[idx[PTR_W-1:0]] = 1'b1;
                    grant_idx                 = idx[PTR_W-1:0];
                end
            end
        end
    end

    assign sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];
    assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef WB_ZERO_REG_EN
    // Register 0 is hardwired: accept the request but suppress the write.
    assign wr_ok = (sel_addr != '0);
`else
    assign wr_ok = 1'b1;
`endif

    // Round-robin pointer moves past the winner only on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= next_ptr;
    end

    // Output register: write pulses for one cycle; address/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= accept && wr_ok;
            if (accept) begin
                write_addr <= sel_addr;
                write_data <= sel_data;
            end
        end
    end

    // Saturating count of accepted requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            grant_count <= '0;
        else if (accept && grant_count != 16'hFFFF)
            grant_count <= grant_count + 16'd1;
    end

    assign inflight_valid = write_enable;
    assign inflight_addr  = write_addr;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus with hand-computed literal
// checks plus a reference model compared on every falling edge.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int AW = 5;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              wb_stall;
    logic              write_enable;
    logic [AW-1:0]     write_addr;
    logic [DW-1:0]     write_data;
    logic              inflight_valid;
    logic [AW-1:0]     inflight_addr;
    logic [15:0]       grant_count;

    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    int n_cmp = 0;
    int n_err = 0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*DW +: DW] = d[i];
        end
    end

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wb_stall(wb_stall),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .inflight_valid(inflight_valid), .inflight_addr(inflight_addr),
        .grant_count(grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected register-file write stream and grant order.
    int          m_ptr;
    logic        m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int          m_cnt;

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ready;
        if (!rst) begin
            m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
            chk("m_rst_we",  64'(write_enable), 64'(0));
            chk("m_rst_cnt", 64'(grant_count),  64'(0));
        end else begin
            g = -1;
            if (!wb_stall)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("m_ready", 64'(req_ready),     64'(exp_ready));
            chk("m_we",    64'(write_enable),  64'(m_we));
            chk("m_addr",  64'(write_addr),    64'(m_addr));
            chk("m_data",  write_data,         m_data);
            chk("m_ifv",   64'(inflight_valid), 64'(m_we));
            chk("m_ifa",   64'(inflight_addr), 64'(m_addr));
            chk("m_cnt",   64'(grant_count),   64'(m_cnt));
            if (g >= 0) begin
`ifdef WB_ZERO_REG_EN
                m_we = (a[g] != 0);
`else
                m_we = 1'b1;
`endif
                m_addr = a[g];
                m_data = d[g];
                m_ptr  = (g + 1) % N;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] pat_v [8];
    logic         pat_s [8];

    initial begin
        rst = 1'b0; wb_stall = 1'b0; req_valid = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
        step(); step();
        rst = 1'b1;

        // Accept one write, then reset asynchronously while write_enable is high.
        a[0] = 5'd1; d[0] = 64'd10;
        a[1] = 5'd2; d[1] = 64'd20;
        a[2] = 5'd3; d[2] = 64'd30;
        req_valid = 3'b111;
        step();
        chk("pre_rst_we", 64'(write_enable), 64'(1));
        #1 rst = 1'b0;
        #1;
        chk("async_rst_we",   64'(write_enable), 64'(0));
        chk("async_rst_addr", 64'(write_addr),   64'(0));
        chk("async_rst_data", write_data,        64'(0));
        chk("async_rst_cnt",  64'(grant_count),  64'(0));
        step();
        rst = 1'b1;

        // Round-robin with all valid: 0,1,2,0,1,2.
        for (int c = 0; c < 6; c++) begin
            #1 chk("rr_ready", 64'(req_ready), 64'(3'b001 << (c % 3)));
            step();
        end
        req_valid = '0;
        #1 chk("rr_cnt", 64'(grant_count), 64'(6));
        chk("rr_last_addr", 64'(write_addr), 64'(3));

        // Single request from requester 1.
        a[1] = 5'd7; d[1] = 64'hDEAD_BEEF;
        req_valid = 3'b010;
        #1 chk("single_ready", 64'(req_ready), 64'(3'b010));
        step();
        req_valid = '0;
        #1;
        chk("single_we",   64'(write_enable), 64'(1));
        chk("single_addr", 64'(write_addr),   64'(7));
        chk("single_data", write_data,        64'hDEAD_BEEF);
        step();
        #1;
        chk("single_we_off", 64'(write_enable), 64'(0));
        chk("single_hold",   64'(write_addr),   64'(7));

        // Stall: no grants for 3 cycles, then resume at requester 2.
        req_valid = 3'b111; wb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall_ready", 64'(req_ready), 64'(0));
            step();
        end
        wb_stall = 1'b0;
        #1 chk("stall_resume", 64'(req_ready), 64'(3'b100));
        step();
        req_valid = '0;

        // Collision: two writes to address 4 land in grant order.
        a[0] = 5'd4; d[0] = 64'd1;
        a[1] = 5'd4; d[1] = 64'd2;
        req_valid = 3'b011;
        #1 chk("coll_ready0", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = 3'b010;
        #1;
        chk("coll_ready1", 64'(req_ready),  64'(3'b010));
        chk("coll_w1_we",  64'(write_enable), 64'(1));
        chk("coll_w1_a",   64'(write_addr), 64'(4));
        chk("coll_w1_d",   write_data,      64'(1));
        step();
        req_valid = '0;
        #1;
        chk("coll_w2_we", 64'(write_enable), 64'(1));
        chk("coll_w2_a",  64'(write_addr),   64'(4));
        chk("coll_w2_d",  write_data,        64'(2));

        // Address 0 write from requester 0 (rr_ptr is 2, only req 0 valid).
        a[0] = 5'd0; d[0] = 64'd5;
        req_valid = 3'b001;
        #1 chk("zero_ready", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = '0;
        #1;
        chk("zero_cnt",  64'(grant_count), 64'(11));
        chk("zero_addr", 64'(write_addr),  64'(0));
        chk("zero_data", write_data,       64'(5));
`ifdef WB_ZERO_REG_EN
        chk("zero_we", 64'(write_enable), 64'(0));
`else
        chk("zero_we", 64'(write_enable), 64'(1));
`endif

        // Mixed patterns checked only by the model.
        pat_v = '{3'b101, 3'b110, 3'b011, 3'b111, 3'b100, 3'b000, 3'b111, 3'b010};
        pat_s = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = AW'(8 + p + i);
                d[i] = 64'(100 * p + i);
            end
            req_valid = pat_v[p];
            wb_stall  = pat_s[p];
            step();
        end
        req_valid = '0; wb_stall = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
